// File: rtl/dsp_alu_pipe.sv
// Pipelined SIMD DSP-slice ALU: optional operand register stage, per-lane
// arithmetic with carry chains broken at lane boundaries, full-width logic
// ops, P-feedback accumulation and a registered pattern detector.
module dsp_alu_pipe #(
    parameter int               WIDTH   = 48,
    parameter int               LANES   = 1,
    parameter int               INREG   = 1,
    parameter logic [WIDTH-1:0] PATTERN = '0,
    parameter logic [WIDTH-1:0] MASK    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cein,
    input  logic             cep,
    input  logic             valid_in,
    input  logic [6:0]       opmode,
    input  logic [3:0]       alumode,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] p,
    output logic [3:0]       carryout,
    output logic             patterndetect,
    output logic             valid_out
);

    localparam int   L        = WIDTH / LANES;
    localparam logic PD_RESET = ((PATTERN & ~MASK) == '0);

    if ((LANES != 1 && LANES != 2 && LANES != 4) || (WIDTH % LANES != 0)) begin : g_bad_cfg
        $error("dsp_alu_pipe: LANES must be 1, 2 or 4 and divide WIDTH");
    end

    // operands as seen by the compute stage
    logic [6:0]       op_s;
    logic [3:0]       alu_s;
    logic             cin_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] z_s;
    logic             valid_s;

    if (INREG != 0) begin : g_inreg
        logic [6:0]       op_q;
        logic [3:0]       alu_q;
        logic             cin_q;
        logic [WIDTH-1:0] x_q;
        logic [WIDTH-1:0] y_q;
        logic [WIDTH-1:0] z_q;
        logic             valid_q;

        // input stage: capture everything on cein, hold otherwise
        always_ff @(posedge clk) begin
            if (rst) begin
                op_q    <= '0;
                alu_q   <= '0;
                cin_q   <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                z_q     <= '0;
                valid_q <= 1'b0;
            end else if (cein) begin
                op_q    <= opmode;
                alu_q   <= alumode;
                cin_q   <= cin;
                x_q     <= x;
                y_q     <= y;
                z_q     <= z;
                valid_q <= valid_in;
            end
        end

        assign op_s    = op_q;
        assign alu_s   = alu_q;
        assign cin_s   = cin_q;
        assign x_s     = x_q;
        assign y_s     = y_q;
        assign z_s     = z_q;
        assign valid_s = valid_q;
    end else begin : g_noreg
        assign op_s    = opmode;
        assign alu_s   = alumode;
        assign cin_s   = cin;
        assign x_s     = x;
        assign y_s     = y;
        assign z_s     = z;
        assign valid_s = valid_in;
    end

    // opmode[1:0] belong to the operand muxes upstream; cein is dead without the input stage
    logic unused_bits;
    assign unused_bits = ^{op_s[1:0], cein};

    // accumulate feeds back P as held at this edge
    logic [WIDTH-1:0] z_eff;
    assign z_eff = (op_s[6:4] == 3'b010) ? p : z_s;

    logic [WIDTH-1:0] arith_p;
    logic [LANES-1:0] arith_c;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [L:0] xe, ye, ze, zn, ce, sum, res;

        assign xe  = {1'b0, x_s[k*L +: L]};
        assign ye  = {1'b0, y_s[k*L +: L]};
        assign ze  = {1'b0, z_eff[k*L +: L]};
        assign zn  = {1'b0, ~z_eff[k*L +: L]};
        assign ce  = (k == 0) ? {{L{1'b0}}, cin_s} : '0;
        assign sum = ze + xe + ye + ce;

        // per-lane (L+1)-bit arithmetic; top bit becomes this lane's carry
        always_comb begin
            res = sum;
            case (alu_s[1:0])
                2'b00:   res = sum;
                2'b01:   res = zn + xe + ye + ce;
                2'b10:   res = ~sum;
                default: res = ze - (xe + ye + ce);
            endcase
        end

        assign arith_p[k*L +: L] = res[L-1:0];
        assign arith_c[k]        = res[L];
    end

    logic [WIDTH-1:0] logic_p;
    logic             col_b;

    // full-width logic ops; opmode[3] picks the second column of each pair
    always_comb begin
        logic_p = '0;
        col_b   = op_s[3];
        if (op_s[2] == 1'b0) begin
            case (alu_s)
                4'b0100, 4'b0111: logic_p = col_b ? ~(x_s ^ z_eff) : (x_s ^ z_eff);
                4'b0101, 4'b0110: logic_p = col_b ? (x_s ^ z_eff) : ~(x_s ^ z_eff);
                4'b1100:          logic_p = col_b ? (x_s | z_eff) : (x_s & z_eff);
                4'b1101:          logic_p = col_b ? (x_s | ~z_eff) : (x_s & ~z_eff);
                4'b1110:          logic_p = col_b ? ~(x_s | z_eff) : ~(x_s & z_eff);
                4'b1111:          logic_p = col_b ? (~x_s & z_eff) : (~x_s | z_eff);
                default:          logic_p = '0;
            endcase
        end
    end

    logic [WIDTH-1:0] p_next;
    logic [3:0]       c_next;

    // result select: arithmetic, logic, or zero for 10xx
    always_comb begin
        p_next = '0;
        c_next = '0;
        case (alu_s[3:2])
            2'b00: begin
                p_next               = arith_p;
                c_next[LANES-1:0]    = arith_c;
            end
            2'b10:   p_next = '0;
            default: p_next = logic_p;
        endcase
    end

    // output stage: P, flags and valid move together on cep
    always_ff @(posedge clk) begin
        if (rst) begin
            p             <= '0;
            carryout      <= '0;
            patterndetect <= PD_RESET;
            valid_out     <= 1'b0;
        end else if (cep) begin
            p             <= p_next;
            carryout      <= c_next;
            patterndetect <= (((p_next ^ PATTERN) & ~MASK) == '0);
            valid_out     <= valid_s;
        end
    end

endmodule

// File: tb/tb_dsp_alu_pipe.sv
// Self-checking bench: three configurations of dsp_alu_pipe driven in
// parallel, directed examples plus randomized traffic against an
// integer-arithmetic reference model.
module tb_dsp_alu_pipe;

    typedef struct packed {
        logic [6:0]  op;
        logic [3:0]  am;
        logic        ci;
        logic [47:0] xv;
        logic [47:0] yv;
        logic [47:0] zv;
        logic        v;
    } in_t;

    localparam int          LN  [3] = '{1, 4, 2};
    localparam int          INR [3] = '{1, 1, 0};
    localparam logic [47:0] PAT [3] = '{48'h10, 48'h0, 48'h5};
    localparam logic [47:0] MSK [3] = '{48'hF, 48'h0, 48'hFFFF_FFFF_FFF0};

    logic        clk = 1'b0;
    logic        rst, cein, cep, vin, cin;
    logic [6:0]  opm;
    logic [3:0]  alm;
    logic [47:0] xi, yi, zi;

    logic [47:0] dp  [3];
    logic [3:0]  dc  [3];
    logic        dpd [3];
    logic        dv  [3];

    in_t         ms1 [3];
    logic [47:0] mp  [3];
    logic [3:0]  mc  [3];
    logic        mpd [3];
    logic        mv  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp_alu_pipe #(.WIDTH(48), .LANES(1), .INREG(1), .PATTERN(48'h10), .MASK(48'hF)) dut0 (
        .clk(clk), .rst(rst), .cein(cein), .cep(cep), .valid_in(vin), .opmode(opm),
        .alumode(alm), .cin(cin), .x(xi), .y(yi), .z(zi), .p(dp[0]), .carryout(dc[0]),
        .patterndetect(dpd[0]), .valid_out(dv[0]));

    dsp_alu_pipe #(.WIDTH(48), .LANES(4), .INREG(1), .PATTERN(48'h0), .MASK(48'h0)) dut1 (
        .clk(clk), .rst(rst), .cein(cein), .cep(cep), .valid_in(vin), .opmode(opm),
        .alumode(alm), .cin(cin), .x(xi), .y(yi), .z(zi), .p(dp[1]), .carryout(dc[1]),
        .patterndetect(dpd[1]), .valid_out(dv[1]));

    dsp_alu_pipe #(.WIDTH(48), .LANES(2), .INREG(0), .PATTERN(48'h5), .MASK(48'hFFFF_FFFF_FFF0)) dut2 (
        .clk(clk), .rst(rst), .cein(cein), .cep(cep), .valid_in(vin), .opmode(opm),
        .alumode(alm), .cin(cin), .x(xi), .y(yi), .z(zi), .p(dp[2]), .carryout(dc[2]),
        .patterndetect(dpd[2]), .valid_out(dv[2]));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // returns {carry[3:0], p[47:0]} computed lane by lane with plain integer arithmetic
    function automatic logic [51:0] ref_alu(input int lanes, input logic [3:0] am, input logic [6:0] om,
                                            input logic ci, input logic [47:0] xa, input logic [47:0] ya,
                                            input logic [47:0] za);
        int                lw;
        longint unsigned   m, mm, xl, yl, zl, cl, r;
        logic [47:0]       pr;
        logic [3:0]        cr;
        logic              col;
        lw = 48 / lanes;
        m  = (64'd1 << lw) - 64'd1;
        mm = (64'd1 << (lw + 1)) - 64'd1;
        pr = '0;
        cr = '0;
        col = om[3];
        if (am[3:2] == 2'b00) begin
            for (int k = 0; k < lanes; k++) begin
                xl = ({16'd0, xa} >> (k * lw)) & m;
                yl = ({16'd0, ya} >> (k * lw)) & m;
                zl = ({16'd0, za} >> (k * lw)) & m;
                cl = (k == 0) ? 64'(ci) : 64'd0;
                case (am[1:0])
                    2'd0:    r = zl + xl + yl + cl;
                    2'd1:    r = (~zl & m) + xl + yl + cl;
                    2'd2:    r = ~(zl + xl + yl + cl);
                    default: r = zl - (xl + yl + cl);
                endcase
                r = r & mm;
                pr = pr | 48'((r & m) << (k * lw));
                cr[k] = r[lw];
            end
        end else if (am[3:2] == 2'b10) begin
            pr = '0;
        end else if (om[3:2] == 2'b00 || om[3:2] == 2'b10) begin
            case (am)
                4'b0100, 4'b0111: pr = col ? ~(xa ^ za) : (xa ^ za);
                4'b0101, 4'b0110: pr = col ? (xa ^ za) : ~(xa ^ za);
                4'b1100:          pr = col ? (xa | za) : (xa & za);
                4'b1101:          pr = col ? (xa | ~za) : (xa & ~za);
                4'b1110:          pr = col ? ~(xa | za) : ~(xa & za);
                default:          pr = col ? (~xa & za) : (~xa | za);
            endcase
        end
        return {cr, pr};
    endfunction

    task automatic model_update();
        in_t         now, cur;
        logic [47:0] zz;
        logic [51:0] r;
        now = '{op: opm, am: alm, ci: cin, xv: xi, yv: yi, zv: zi, v: vin};
        for (int k = 0; k < 3; k++) begin
            cur = (INR[k] != 0) ? ms1[k] : now;
            if (rst) begin
                ms1[k] = '0;
                mp[k]  = '0;
                mc[k]  = '0;
                mpd[k] = ((PAT[k] & ~MSK[k]) == 48'd0);
                mv[k]  = 1'b0;
            end else begin
                if (cep) begin
                    zz     = (cur.op[6:4] == 3'b010) ? mp[k] : cur.zv;
                    r      = ref_alu(LN[k], cur.am, cur.op, cur.ci, cur.xv, cur.yv, zz);
                    mp[k]  = r[47:0];
                    mc[k]  = r[51:48];
                    mpd[k] = (((mp[k] ^ PAT[k]) & ~MSK[k]) == 48'd0);
                    mv[k]  = cur.v;
                end
                if (cein) ms1[k] = now;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("m%0d_p", k),  64'(dp[k]),  64'(mp[k]));
            check_val($sformatf("m%0d_c", k),  64'(dc[k]),  64'(mc[k]));
            check_val($sformatf("m%0d_pd", k), 64'(dpd[k]), 64'(mpd[k]));
            check_val($sformatf("m%0d_v", k),  64'(dv[k]),  64'(mv[k]));
        end
    endtask

    function automatic logic [47:0] rand_operand();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return 48'h000F_FF00_0FFF;
            2:       return 48'(w[7:0]);
            default: return w[47:0];
        endcase
    endfunction

    initial begin
        rst = 1'b1; cein = 1'b1; cep = 1'b1; vin = 1'b0; cin = 1'b0;
        opm = '0; alm = '0; xi = '0; yi = '0; zi = '0;
        tick();
        tick();
        check_val("rst_p0",  64'(dp[0]),  64'd0);
        check_val("rst_v0",  64'(dv[0]),  64'd0);
        check_val("rst_pd0", 64'(dpd[0]), 64'd0);
        check_val("rst_pd1", 64'(dpd[1]), 64'd1);
        check_val("rst_pd2", 64'(dpd[2]), 64'd0);
        rst = 1'b0;

        // basic add with latency 2
        xi = 48'd1; yi = 48'd2; zi = 48'd3; cin = 1'b1; alm = 4'b0000; opm = '0; vin = 1'b1;
        tick();
        vin = 1'b0;
        check_val("t1_v_edge1", 64'(dv[0]), 64'd0);
        tick();
        check_val("t1_p", 64'(dp[0]), 64'd7);
        check_val("t1_c", 64'(dc[0]), 64'd0);
        check_val("t1_v_edge2", 64'(dv[0]), 64'd1);
        tick();
        check_val("t1_v_edge3", 64'(dv[0]), 64'd0);

        // subtract and borrow
        xi = '0; yi = '0; zi = 48'd1; cin = 1'b0; alm = 4'b0011;
        tick(); tick();
        check_val("t2_p1", 64'(dp[0]), 64'd1);
        check_val("t2_c1", 64'(dc[0]), 64'd0);
        xi = 48'd1; zi = '0;
        tick(); tick();
        check_val("t2_pneg", 64'(dp[0]), 64'hFFFF_FFFF_FFFF);
        check_val("t2_cneg", 64'(dc[0]), 64'd1);

        // lane boundary on the 4-lane instance
        xi = 48'd1; yi = '0; zi = 48'h000_000_000_FFF; alm = 4'b0000;
        tick(); tick();
        check_val("t3_p4", 64'(dp[1]), 64'd0);
        check_val("t3_c4", 64'(dc[1]), 64'b0001);

        // accumulate, reset mid-run, restart, then stall the input stage
        rst = 1'b1; opm = 7'b010_0000; xi = 48'd5; yi = '0; zi = '0; cin = 1'b0; alm = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        tick(); check_val("t4_acc5",  64'(dp[0]), 64'd5);
        tick(); check_val("t4_acc10", 64'(dp[0]), 64'd10);
        tick(); check_val("t4_acc15", 64'(dp[0]), 64'd15);
        tick(); check_val("t4_acc20", 64'(dp[0]), 64'd20);
        rst = 1'b1;
        tick(); check_val("t4_rst", 64'(dp[0]), 64'd0);
        rst = 1'b0;
        tick(); tick(); check_val("t4_restart", 64'(dp[0]), 64'd5);
        cein = 1'b0; xi = 48'd100;
        tick(); check_val("t4_held_s1", 64'(dp[0]), 64'd10);
        cein = 1'b1;

        // logic ops
        opm = 7'b000_1000; alm = 4'b1100; xi = 48'hF0F0; zi = 48'h00FF; yi = '0;
        tick(); tick();
        check_val("t5_or", 64'(dp[0]), 64'hF0FF);
        opm = 7'b000_0100;
        tick(); tick();
        check_val("t5_bad_sel", 64'(dp[0]), 64'd0);

        // pattern detect and output hold
        opm = '0; alm = 4'b0000; xi = 48'h1A; yi = '0; zi = '0; cin = 1'b0;
        tick(); tick();
        check_val("t6_p1a",  64'(dp[0]),  64'h1A);
        check_val("t6_pd1a", 64'(dpd[0]), 64'd1);
        xi = 48'h2A;
        tick(); tick();
        check_val("t6_pd2a", 64'(dpd[0]), 64'd0);
        cep = 1'b0; xi = 48'h1A;
        tick(); tick();
        check_val("t6_hold_p",  64'(dp[0]),  64'h2A);
        check_val("t6_hold_pd", 64'(dpd[0]), 64'd0);
        cep = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            cein = ($urandom_range(0, 3) != 0);
            cep  = ($urandom_range(0, 3) != 0);
            vin  = 1'($urandom);
            cin  = 1'($urandom);
            alm  = 4'($urandom);
            opm  = 7'($urandom);
            if ($urandom_range(0, 2) == 0) opm[6:4] = 3'b010;
            xi = rand_operand();
            yi = rand_operand();
            zi = rand_operand();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
